// File: rtl/undolog_ctrl_regs.sv
// AXI4-Lite control/status register bank for the undo-log engine: CTRL doorbell, STATUS with W1C DONE, RW config regs.
// Optional level interrupt output is built only when UNDOLOG_IRQ_EN is defined.
module undolog_ctrl_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS         = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                                             s00_axi_aclk,
  input  logic                                             s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                    s00_axi_awaddr,
  input  logic [2:0]                                       s00_axi_awprot,
  input  logic                                             s00_axi_awvalid,
  output logic                                             s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                    s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                  s00_axi_wstrb,
  input  logic                                             s00_axi_wvalid,
  output logic                                             s00_axi_wready,
  output logic [1:0]                                       s00_axi_bresp,
  output logic                                             s00_axi_bvalid,
  input  logic                                             s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                    s00_axi_araddr,
  input  logic [2:0]                                       s00_axi_arprot,
  input  logic                                             s00_axi_arvalid,
  output logic                                             s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                    s00_axi_rdata,
  output logic [1:0]                                       s00_axi_rresp,
  output logic                                             s00_axi_rvalid,
  input  logic                                             s00_axi_rready,
  input  logic                                             eng_busy,
  input  logic                                             eng_done,
  output logic                                             ctrl_start,
  output logic [(C_NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0]     cfg_regs,
  output logic                                             irq
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int LSB   = $clog2(SW);
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - LSB;
  // One extra bit so the range check still works when the index field cannot exceed C_NUM_REGS-1
  localparam logic [IDX_W:0] NREG = (IDX_W+1)'(C_NUM_REGS);

  typedef enum logic [1:0] {WR_IDLE, WR_ACC, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ACC, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_err, rd_err;
  logic             wr_acc, rd_acc;
  logic [DW-1:0]    cfg [C_NUM_REGS-2];
  logic             done;
  logic [DW-1:0]    rd_value;
  logic             unused_bits;

  assign wr_idx = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:LSB];
  assign rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:LSB];
  assign wr_err = {1'b0, wr_idx} >= NREG;
  assign rd_err = {1'b0, rd_idx} >= NREG;
  assign wr_acc = (wr_state == WR_ACC);
  assign rd_acc = (rd_state == RD_ACC);

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[LSB-1:0], s00_axi_araddr[LSB-1:0]};

  // Handshake outputs decode the state register, so an async reset drops them at once
  assign s00_axi_awready = wr_acc;
  assign s00_axi_wready  = wr_acc;
  assign s00_axi_bvalid  = (wr_state == WR_RESP);
  assign s00_axi_arready = rd_acc;
  assign s00_axi_rvalid  = (rd_state == RD_DATA);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) wr_next = WR_ACC;
      WR_ACC:  wr_next = WR_RESP;
      WR_RESP: if (s00_axi_bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (s00_axi_arvalid) rd_next = RD_ACC;
      RD_ACC:  rd_next = RD_DATA;
      RD_DATA: if (s00_axi_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int r = 0; r < C_NUM_REGS-2; r++) cfg[r] <= '0;
      done       <= 1'b0;
      ctrl_start <= 1'b0;
    end else begin
      ctrl_start <= wr_acc && (wr_idx == IDX_W'(0)) && s00_axi_wstrb[0] && s00_axi_wdata[0];
      for (int r = 2; r < C_NUM_REGS; r++) begin
        if (wr_acc && (wr_idx == IDX_W'(r))) begin
          for (int b = 0; b < SW; b++) begin
            if (s00_axi_wstrb[b]) cfg[r-2][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
          end
        end
      end
      // A DONE event in the same cycle as its W1C wins, so no completion is lost
      if (eng_done)
        done <= 1'b1;
      else if (wr_acc && (wr_idx == IDX_W'(1)) && s00_axi_wstrb[0] && s00_axi_wdata[1])
        done <= 1'b0;
    end
  end

`ifdef UNDOLOG_IRQ_EN
  logic irq_en;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_acc && (wr_idx == IDX_W'(0)) && s00_axi_wstrb[0]) irq_en <= s00_axi_wdata[1];
      irq <= irq_en && done;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_value = '0;
    if (rd_idx == IDX_W'(0)) begin
`ifdef UNDOLOG_IRQ_EN
      rd_value[1] = irq_en;
`endif
    end else if (rd_idx == IDX_W'(1)) begin
      rd_value[1:0] = {done, eng_busy};
    end else begin
      for (int r = 2; r < C_NUM_REGS; r++) begin
        if (rd_idx == IDX_W'(r)) rd_value = cfg[r-2];
      end
    end
  end

  // Responses are captured on the accept edge and held until the master takes them
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_bresp <= 2'b00;
      s00_axi_rresp <= 2'b00;
      s00_axi_rdata <= '0;
    end else begin
      if (wr_acc) s00_axi_bresp <= wr_err ? 2'b10 : 2'b00;
      if (rd_acc) begin
        s00_axi_rresp <= rd_err ? 2'b10 : 2'b00;
        s00_axi_rdata <= rd_value;
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS-2; g++) begin : g_cfg
    assign cfg_regs[g*DW +: DW] = cfg[g];
  end

endmodule
